// File: rtl/register_file_sb.sv
//------------------------------------------------------------------------------
// Module   : register_file_sb
// Brief    : 2-read/2-write register file with write-through bypass and a
//            per-register pending-load scoreboard for hazard detection.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module register_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r_wr_en,
    input  logic [ADDR_W-1:0] w_reg,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_wr2_en,
    input  logic [ADDR_W-1:0] w_reg2,
    input  logic [DATA_W-1:0] w_data2,
    input  logic              sb_set_en,
    input  logic [ADDR_W-1:0] sb_set_reg,
    input  logic [ADDR_W-1:0] r_reg1,
    input  logic [ADDR_W-1:0] r_reg2,
    output logic [DATA_W-1:0] r1_data,
    output logic [DATA_W-1:0] r2_data,
    output logic              r1_busy,
    output logic              r2_busy,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int          c_DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] c_ONE = (ADDR_W+1)'(1);

    logic [DATA_W-1:0]  mem_q [c_DEPTH];
    logic [DATA_W-1:0]  mem_d [c_DEPTH];
    logic [c_DEPTH-1:0] busy_q;
    logic [c_DEPTH-1:0] busy_d;
    logic [ADDR_W:0]    cnt_q;
    logic [ADDR_W:0]    cnt_d;

    logic w_a_ok;
    logic w_b_ok;
    logic w_set_ok;
    logic w_inc;
    logic w_dec;

    // Register 0 is filtered out of every write/set/clear when hardwired.
    always_comb begin
        w_a_ok   = r_wr_en   && !((ZERO_REG != 0) && (w_reg == '0));
        w_b_ok   = r_wr2_en  && !((ZERO_REG != 0) && (w_reg2 == '0));
        w_set_ok = sb_set_en && !((ZERO_REG != 0) && (sb_set_reg == '0));
    end

    // Port A is applied last so it wins an address collision with port B.
    always_comb begin
        mem_d = mem_q;
        if (w_b_ok) begin
            mem_d[w_reg2] = w_data2;
        end
        if (w_a_ok) begin
            mem_d[w_reg] = w_data;
        end
    end

    // Set is applied after clear so a same-cycle set/clear leaves the bit at 1.
    always_comb begin
        busy_d = busy_q;
        if (w_b_ok) begin
            busy_d[w_reg2] = 1'b0;
        end
        if (w_set_ok) begin
            busy_d[sb_set_reg] = 1'b1;
        end
    end

    always_comb begin
        w_inc = w_set_ok && !busy_q[sb_set_reg];
        w_dec = w_b_ok && busy_q[w_reg2] && !(w_set_ok && (sb_set_reg == w_reg2));
        cnt_d = cnt_q;
        if (w_inc && !w_dec) begin
            cnt_d = cnt_q + c_ONE;
        end else if (w_dec && !w_inc) begin
            cnt_d = cnt_q - c_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Read mux: zero register, then port A, then port B, then array.
    always_comb begin
        if (rst || ((ZERO_REG != 0) && (r_reg1 == '0))) begin
            r1_data = '0;
        end else if (r_wr_en && (w_reg == r_reg1)) begin
            r1_data = w_data;
        end else if (r_wr2_en && (w_reg2 == r_reg1)) begin
            r1_data = w_data2;
        end else begin
            r1_data = mem_q[r_reg1];
        end

        if (rst || ((ZERO_REG != 0) && (r_reg2 == '0))) begin
            r2_data = '0;
        end else if (r_wr_en && (w_reg == r_reg2)) begin
            r2_data = w_data;
        end else if (r_wr2_en && (w_reg2 == r_reg2)) begin
            r2_data = w_data2;
        end else begin
            r2_data = mem_q[r_reg2];
        end
    end

    assign r1_busy  = busy_q[r_reg1];
    assign r2_busy  = busy_q[r_reg2];
    assign busy_cnt = cnt_q;

endmodule

`default_nettype wire
